// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Multi-cycle unsigned shift-and-add multiplier. It reuses the
//            external 2*WIDTH-bit ripple adder for every partial-product
//            accumulation, one multiplier bit per cycle.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start          - request, accepted while ready=1
//            mcand, mplier  - unsigned operands, captured on accepted start
//            ready          - high in IDLE and DONE
//            done           - one-cycle pulse, product valid
//            product        - 2*WIDTH result, held until next accepted start
//            add_a, add_b   - operands to the external adder
//            add_c_in       - adder carry-in, tied to 0
//            add_sum        - combinational sum returned by the adder
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   add_a,
  output logic [2*WIDTH-1:0]   add_b,
  output logic                 add_c_in,
  input  logic [2*WIDTH-1:0]   add_sum
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [2*WIDTH-1:0]   mc_sh_q,   mc_sh_d;
  logic [WIDTH-1:0]     mp_sh_q,   mp_sh_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 ready_q,   ready_d;
  logic                 done_q,    done_d;

  // Adder operands come straight from registers so the only long path is
  // acc -> external carry chain -> add_sum -> acc.
  assign add_a    = acc_q;
  assign add_b    = (state_q == S_RUN && mp_sh_q[0]) ? mc_sh_q : '0;
  assign add_c_in = 1'b0;

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mc_sh_d   = mc_sh_q;
    mp_sh_d   = mp_sh_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start directly for back-to-back throughput.
        if (start) begin
          acc_d   = '0;
          mc_sh_d = {{WIDTH{1'b0}}, mcand};
          mp_sh_d = mplier;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = add_sum;
        mc_sh_d = mc_sh_q << 1;
        mp_sh_d = mp_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          product_d = add_sum;
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state.
    ready_d = (state_d != S_RUN);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mc_sh_q   <= '0;
      mp_sh_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_sh_q   <= mc_sh_d;
      mp_sh_q   <= mp_sh_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Purpose  : Self-checking bench for shift_add_multiplier with a behavioural
//            64-bit adder attached to the add_* port group.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   mcand = '0;
  logic [WIDTH-1:0]   mplier = '0;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] add_a;
  logic [2*WIDTH-1:0] add_b;
  logic               add_c_in;
  logic [2*WIDTH-1:0] add_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Behavioural stand-in for sixty_four_bit_adder.
  assign add_sum = add_a + add_b + {{(2*WIDTH-1){1'b0}}, add_c_in};

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .ready    (ready),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_c_in (add_c_in),
    .add_sum  (add_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Continuous properties: carry-in tied low, done is a single-cycle pulse.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("add_c_in_zero", {63'd0, add_c_in}, 64'd0);
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", {63'd0, done_prev}, 64'd0);
      end
    end
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands and start; returns cycle count just after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int acc_cyc);
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    if (!ready) chk("ready_timeout", {63'd0, ready}, 64'd1);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    step();
    start  = 1'b0;
    acc_cyc = cyc;
    chk("ready_fall", {63'd0, ready}, 64'd0);
  endtask

  task automatic wait_done(input string nm, input logic [63:0] exp, input int acc_cyc);
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    if (!done) begin
      chk({nm, "_done_timeout"}, {63'd0, done}, 64'd1);
    end else begin
      chk({nm, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(LAT));
      chk({nm, "_product"}, product, exp);
      chk({nm, "_ready_at_done"}, {63'd0, ready}, 64'd1);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   ac;
    int   d0;

    vecs[0] = '{32'd3,          32'd4,          64'd12};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
    vecs[3] = '{32'h8000_0000,  32'd1,          64'h0000_0000_8000_0000};
    vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_ready",   {63'd0, ready},    64'd1);
    chk("rst_done",    {63'd0, done},     64'd0);
    chk("rst_product", product,           64'd0);
    chk("rst_add_a",   add_a,             64'd0);
    chk("rst_add_b",   add_b,             64'd0);
    chk("rst_c_in",    {63'd0, add_c_in}, 64'd0);
    rst = 1'b0;
    step();

    // Directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, ac);
      wait_done($sformatf("vec%0d", i), vecs[i].p, ac);
      step();
      chk($sformatf("vec%0d_hold", i), product, vecs[i].p);
      chk($sformatf("vec%0d_idle_ready", i), {63'd0, ready}, 64'd1);
    end

    // Randomized operands against plain multiplication
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom;
      b = $urandom;
      start_op(a, b, ac);
      wait_done($sformatf("rand%0d", i), 64'(a) * 64'(b), ac);
    end

    // Busy: start during RUN is ignored, operand changes have no effect
    step();
    d0 = done_cnt;
    start_op(32'd5, 32'd6, ac);
    repeat (9) step();
    mcand  = 32'd7;
    mplier = 32'd8;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mcand  = 32'h1234;
    mplier = 32'h99;
    wait_done("busy", 64'd30, ac);
    repeat (40) step();
    chk("busy_one_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_idle_ready", {63'd0, ready}, 64'd1);

    // Back-to-back: restart from the DONE cycle
    start_op(32'd2, 32'd3, ac);
    wait_done("b2b_first", 64'd6, ac);
    mcand  = 32'd9;
    mplier = 32'd9;
    start  = 1'b1;
    step();
    ac = cyc;
    start  = 1'b0;
    chk("b2b_restart_ready", {63'd0, ready}, 64'd0);
    wait_done("b2b_second", 64'd81, ac);
    step();

    // Reset mid-operation
    start_op(32'd100, 32'd200, ac);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_product", product,        64'd0);
    chk("midrst_done",    {63'd0, done},  64'd0);
    chk("midrst_ready",   {63'd0, ready}, 64'd1);
    d0 = done_cnt;
    repeat (40) step();
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    start_op(32'd7, 32'd7, ac);
    wait_done("after_rst", 64'd49, ac);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Multi-cycle unsigned multiplier that sits directly upstream of the 64-bit ripple adder (`sixty_four_bit_adder`) in the ALU. Each cycle it drives the adder's `a`/`b`/`c_in` with the running partial product and the shifted multiplicand. It captures the adder's `sum` back into its accumulator. After WIDTH iterations it presents a 2*WIDTH-bit product with a one-cycle `done` pulse.

## Interface
- WIDTH, 32, operand width; product and adder path are 2*WIDTH (64) bits wide.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only when `ready`=1.
- mcand  input  WIDTH  multiplicand; unsigned; captured on accepted start.
- mplier  input  WIDTH  multiplier; unsigned; captured on accepted start.
- ready  output  1  high in IDLE and DONE; start is accepted this cycle.
- done  output  1  one-cycle pulse; `product` is valid.
- product  output  2*WIDTH  result register; holds until the next accepted start.
- add_a  output  2*WIDTH  to adder `a`.
- add_b  output  2*WIDTH  to adder `b`.
- add_c_in  output  1  to adder `c_in`; constant 0.
- add_sum  input  2*WIDTH  from adder `sum`; combinational, same cycle.

## Operation
- Internal state: `acc` (2*WIDTH), `mc_sh` (2*WIDTH), `mp_sh` (WIDTH), iteration counter `cnt` (0..WIDTH-1).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1, done=0.
  - On start=1, load the registers: acc←0, mc_sh←zero-extended mcand, mp_sh←mplier, cnt←0.
  - Next state is RUN.
- RUN: each cycle does the following.
  - Drive add_a=acc and add_b = mp_sh[0] ? mc_sh : 0.
  - Update acc←add_sum, mc_sh←mc_sh<<1, mp_sh←mp_sh>>1, cnt←cnt+1.
  - When cnt=WIDTH-1, perform the final update, copy the result into `product` (product←add_sum), and go to DONE.
- DONE:
  - done=1 and ready=1 for exactly one cycle.
  - If start=1, reload as in IDLE and go to RUN (back-to-back operation). Otherwise go to IDLE.
- Outside RUN, add_a=acc and add_b=0, so the adder output is don't-care and ignored.
- Arithmetic is unsigned modulo 2^(2*WIDTH). The product never overflows 2*WIDTH bits.
- There is no early termination. Latency is fixed regardless of operand values.
- start while in RUN is ignored: no effect, and there is no queued request.
- mcand/mplier changes after capture have no effect on the operation in flight.

## Timing
- Reset (rst=1 at an edge) gives:
  - state=IDLE; acc, mc_sh, mp_sh, cnt, product all 0.
  - done=0, ready=1, add_a=0, add_b=0, add_c_in=0.
- Reset takes priority over start and over any state. A reset mid-RUN aborts the operation: product is cleared to 0 and no done pulse is produced.
- Latency, with start accepted at edge E0:
  - RUN occupies the cycles after edges E0..E(WIDTH-1).
  - product updates at edge E(WIDTH).
  - done is high in the cycle following E(WIDTH), i.e. WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Critical path: acc → external adder carry chain → add_sum → acc. Both add_a and add_b are driven from registers only.

## Test plan
- Basic product:
  - Stimulus: mcand=3, mplier=4, start for one cycle.
  - Required: ready falls the next cycle; done pulses exactly 33 cycles after start accepted; product=12; ready=1 again.
- Maximum operands:
  - Stimulus: mcand=0xFFFFFFFF, mplier=0xFFFFFFFF.
  - Required: product=0xFFFFFFFE00000001.
- Zero and identity:
  - Stimulus: mcand=0, mplier=0xDEADBEEF.
  - Required: product=0.
  - Stimulus: mcand=0x80000000, mplier=1.
  - Required: product=0x0000000080000000.
  - Both cases also require add_c_in=0 throughout.
- Busy and operand stability:
  - Stimulus: start 5×6; at cycle 10 of RUN, assert start with 7×8 and change mcand/mplier.
  - Required: the new start is ignored; product=30; exactly one done pulse.
- Back-to-back:
  - Stimulus: start 2×3, then hold start=1 with 9×9 presented during the DONE cycle.
  - Required: product=6 with done; then RUN restarts immediately; product=81 with done 33 cycles later.
- Reset mid-operation:
  - Stimulus: start 100×200, assert rst for one cycle at RUN cycle 15.
  - Required: next cycle product=0, done=0, ready=1; no done pulse follows.
  - A subsequent start with 7×7 gives product=49.
